ej32_divider_seq: RTL and testbench
===================================

// Module: ej32_divider_seq
// PURPOSE
//  Multi-cycle sequencer for the shared 32-bit restoring divider used by idiv/irem.
//  Sits beside the eJ32 ALU: the decoder pulses start with TOS/NOS, stalls on busy_o,
//  and writes res_o to TOS on done_o.
//  Implements JVM semantics:
//  - quotient truncates toward zero;
//  - remainder takes the sign of the dividend;
//  - divide-by-zero is flagged.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  start_i  in   1      one-cycle request; sampled only in IDLE
//  rem_i    in   1      0 = idiv (quotient), 1 = irem (remainder); sampled with start_i
//  s_i      in   WIDTH  dividend (NOS), two's complement
//  t_i      in   WIDTH  divisor (TOS), two's complement
//  busy_o   out  1      high from cycle after accepted start through DONE
//  done_o   out  1      one-cycle pulse, result valid
//  div0_o   out  1      with done_o: divisor was zero (ArithmeticException)
//  res_o    out  WIDTH  result; held stable until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - state=IDLE; busy_o=0, done_o=0, div0_o=0, res_o=0; counter and work regs cleared.
//  States and transitions
//  - IDLE -> LOAD on start_i.
//    - Latch rem_i, sign_q = s^t (MSBs), sign_r = s MSB.
//    - Latch |s| into Q and |t| into D; clear R (WIDTH+1 bits).
//  - LOAD (1 cycle)
//    - D==0: go to DONE with div0 set.
//    - Otherwise: cnt=WIDTH-1, go to CALC.
//  - CALC (WIDTH cycles), each cycle:
//    - {R,Q} <<= 1;
//    - trial = R' - D;
//    - if trial >= 0 then R = trial and Q[0] = 1;
//    - on cnt==0 go to FIX, else cnt--.
//  - FIX (1 cycle):
//    - res = rem ? (sign_r ? -R : R) : (sign_q ? -Q : Q);
//    - truncate to WIDTH bits.
//  - DONE (1 cycle): done_o=1, div0_o = div0 flag, then go to IDLE.
//    - res_o updates on entry to DONE.
//    - div0 forces res_o=0.
//  Latency, start sampled at edge 0
//  - Normal: done_o high in cycle 35 (WIDTH+3).
//  - Divide-by-zero: done_o high in cycle 2.
//  - Next start accepted in the cycle after DONE (IDLE).
//  busy_o = (state != IDLE).
//  - start_i while busy is ignored: no effect on operands, result or timing.
//  Arithmetic
//  - |x| of MIN (0x8000_0000) = 0x8000_0000 as unsigned, so the magnitude path is WIDTH-bit unsigned.
//  - MIN/-1 gives quotient 0x8000_0000 (wrap, no flag) and remainder 0.
//  - MIN/1 = MIN.
//  - |s| < |t| gives quotient 0 and remainder s.
//  - Negating a zero result yields 0 (never -0 issues).
//  Reset mid-operation
//  - Immediate return to IDLE.
//  - No done_o pulse.
//  - res_o cleared to 0.
//  res_o and div0_o
//  - Both hold until the next accepted start.
//  - On that start, div0_o clears in the LOAD cycle.
// TESTING
//  1. s=100, t=7, rem=0 -> done_o at +35, res_o=14, div0_o=0; busy_o high cycles 1..35.
//  2. s=-100 (0xFFFF_FF9C), t=7, rem=1 -> res_o=-2 (0xFFFF_FFFE); with rem=0 -> -14 (0xFFFF_FFF2).
//  3. s=0x8000_0000, t=0xFFFF_FFFF: rem=0 -> 0x8000_0000; rem=1 -> 0; no div0.
//  4. s=5, t=0 -> done_o at +2, div0_o=1, res_o=0; next start 9/3 completes normally -> 3, div0_o=0.
//  5. Second start_i pulsed at +10 with s=1, t=1 during 100/7 -> ignored; single done_o at +35 with res_o=14.
//  6. rst_n low at +10 of an op -> busy_o/done_o/res_o=0 asynchronously; after release, 7/7 rem=1 -> res_o=0 at +35.

Source files
------------

// File: rtl/ej32_divider_seq_if.sv
// Request/response bundle between the eJ32 decoder and the shared divider sequencer.
// The decoder side drives operands and start; the divider answers with busy/done/result.
interface ej32_divider_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             rem_i;
    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] t_i;
    logic             busy_o;
    logic             done_o;
    logic             div0_o;
    logic [WIDTH-1:0] res_o;

    modport master (
        output start_i, rem_i, s_i, t_i,
        input  busy_o, done_o, div0_o, res_o
    );

    modport slave (
        input  start_i, rem_i, s_i, t_i,
        output busy_o, done_o, div0_o, res_o
    );
endinterface

// File: rtl/ej32_divider_seq.sv
// Multi-cycle restoring divider for idiv/irem with JVM semantics: quotient truncates
// toward zero, remainder follows the dividend sign, divide-by-zero is flagged.
module ej32_divider_seq #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    ej32_divider_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_rem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;

    logic             w_busy;
    logic             w_done;
    logic [WIDTH+1:0] w_r_sh;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_fix;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] z;
        z = '0;
        return z - x;
    endfunction

    // Magnitude is unsigned WIDTH bits, so the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? f_neg(x) : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE);
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start_i) w_next = S_LOAD;
            S_LOAD: w_next = (r_d == '0) ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into R and try subtracting D.
    assign w_r_sh  = {r_r, r_q[WIDTH-1]};
    assign w_trial = w_r_sh - {2'b00, r_d};
    assign w_fits  = ~w_trial[WIDTH+1];

    assign w_fix = r_rem ? (r_sign_r ? f_neg(r_r[WIDTH-1:0]) : r_r[WIDTH-1:0])
                         : (r_sign_q ? f_neg(r_q) : r_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_q      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_rem    <= bus.rem_i;
                        r_sign_q <= bus.s_i[WIDTH-1] ^ bus.t_i[WIDTH-1];
                        r_sign_r <= bus.s_i[WIDTH-1];
                        r_q      <= f_abs(bus.s_i);
                        r_d      <= f_abs(bus.t_i);
                        r_r      <= '0;
                        r_div0   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_d == '0) begin
                        r_div0 <= 1'b1;
                        r_res  <= '0;
                    end else begin
                        r_cnt <= CNT_W'(WIDTH - 1);
                    end
                end
                S_CALC: begin
                    r_q <= {r_q[WIDTH-2:0], w_fits};
                    r_r <= w_fits ? w_trial[WIDTH:0] : w_r_sh[WIDTH:0];
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_res <= w_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o = w_busy;
    assign bus.done_o = w_done;
    assign bus.div0_o = r_div0;
    assign bus.res_o  = r_res;
endmodule

// File: tb/tb_ej32_divider_seq.sv
// Self-checking bench for ej32_divider_seq: cycle-level reference model plus directed
// literal cases and randomized idiv/irem operations.
module tb_ej32_divider_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ej32_divider_seq_if #(.WIDTH(32)) bus ();

    ej32_divider_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // JVM idiv/irem from plain signed arithmetic, with the two special cases spelled out.
    function automatic logic [31:0] ref_res(input logic [31:0] s, input logic [31:0] t,
                                            input logic r);
        int ss;
        int tt;
        ss = s;
        tt = t;
        if (t == 32'd0) return 32'd0;
        if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        return r ? 32'(ss % tt) : 32'(ss / tt);
    endfunction

    // Model: phase counts cycles since the accepting edge; done is due in cycle m_n.
    int          m_phase;
    int          m_n;
    logic [31:0] m_res;
    logic        m_div0;
    logic [31:0] m_pend_res;
    logic        m_pend_div0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_n     <= 0;
            m_res   <= 32'd0;
            m_div0  <= 1'b0;
        end else if (m_phase == 0) begin
            if (bus.start_i) begin
                m_phase     <= 1;
                m_n         <= (bus.t_i == 32'd0) ? 2 : 35;
                m_div0      <= 1'b0;
                m_pend_res  <= ref_res(bus.s_i, bus.t_i, bus.rem_i);
                m_pend_div0 <= (bus.t_i == 32'd0);
            end
        end else if (m_phase == m_n) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 == m_n) begin
                m_res  <= m_pend_res;
                m_div0 <= m_pend_div0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", {31'd0, bus.busy_o}, {31'd0, m_phase != 0});
        chk("model_done", {31'd0, bus.done_o}, {31'd0, (m_phase != 0) && (m_phase == m_n)});
        chk("model_div0", {31'd0, bus.div0_o}, {31'd0, m_div0});
        chk("model_res", bus.res_o, m_res);
    end

    // Issue one operation from IDLE and wait (bounded) for done; optional stray start.
    task automatic do_op(input string nm, input logic [31:0] s, input logic [31:0] t,
                         input logic r, input logic [31:0] exp_res, input logic exp_div0,
                         input int exp_lat, input int inj_at);
        int k;
        bus.start_i = 1'b1;
        bus.s_i     = s;
        bus.t_i     = t;
        bus.rem_i   = r;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        k = 1;
        while (!bus.done_o && k < 60) begin
            if (k == inj_at) begin
                bus.start_i = 1'b1;
                bus.s_i     = 32'd1;
                bus.t_i     = 32'd1;
                bus.rem_i   = 1'b0;
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.start_i = 1'b0;
        chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
        chk({nm, "_res"}, bus.res_o, exp_res);
        chk({nm, "_div0"}, {31'd0, bus.div0_o}, {31'd0, exp_div0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [31:0] s, t;
        logic r;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.rem_i   = 1'b0;
        bus.s_i     = 32'd0;
        bus.t_i     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("reset_done", {31'd0, bus.done_o}, 32'd0);
        chk("reset_div0", {31'd0, bus.div0_o}, 32'd0);
        chk("reset_res", bus.res_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("t1_100div7", 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 35, 0);
        do_op("t2_m100rem7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 35, 0);
        do_op("t2_m100div7", 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFF2, 1'b0, 35, 0);
        do_op("t3_mindivm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 35, 0);
        do_op("t3_minremm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 35, 0);
        do_op("mindiv1", 32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 35, 0);
        do_op("small_rem", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'hFFFF_FFFD, 1'b0, 35, 0);
        do_op("small_div", 32'hFFFF_FFFD, 32'd10, 1'b0, 32'd0, 1'b0, 35, 0);
        do_op("t4_div0", 32'd5, 32'd0, 1'b0, 32'd0, 1'b1, 2, 0);
        do_op("t4_after", 32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 35, 0);
        do_op("t5_ignored", 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 35, 10);

        // Asynchronous reset in the middle of an operation.
        bus.start_i = 1'b1;
        bus.s_i     = 32'd100;
        bus.t_i     = 32'd7;
        bus.rem_i   = 1'b0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        for (k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_done", {31'd0, bus.done_o}, 32'd0);
        chk("t6_res", bus.res_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("t6_7rem7", 32'd7, 32'd7, 1'b1, 32'd0, 1'b0, 35, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: t = 32'd0;
                1: t = 32'hFFFF_FFFF;
                2: t = 32'd1;
                3: t = $urandom_range(0, 1) ? 32'($urandom_range(1, 15))
                                             : -32'($urandom_range(1, 15));
                default: t = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: s = 32'h8000_0000;
                1: s = $urandom_range(0, 1) ? 32'($urandom_range(0, 20))
                                             : -32'($urandom_range(0, 20));
                default: s = $urandom;
            endcase
            r = 1'($urandom_range(0, 1));
            do_op("rand", s, t, r, ref_res(s, t, r), t == 32'd0, (t == 32'd0) ? 2 : 35, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
